// File: rtl/fft64_twiddle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft64_twiddle_sequencer: pairs each sample with twiddle[idx] through a    |
// | 2-entry FIFO and checks frame alignment. Option macro: TWIDDLE_TRIVIAL_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fft64_twiddle_sequencer #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FRAME_LEN-1:0][DATA_W-1:0] w64r,
  input  logic [FRAME_LEN-1:0][DATA_W-1:0] w64i,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_re,
  input  logic [DATA_W-1:0]                in_im,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_re,
  output logic [DATA_W-1:0]                out_im,
  output logic [DATA_W-1:0]                out_wr,
  output logic [DATA_W-1:0]                out_wi,
  output logic [IDX_W-1:0]                 out_idx,
  output logic                             out_last,
  output logic                             out_trivial,
  output logic                             frame_err
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_LEN - 1);
  localparam int               c_depth    = 2;

  logic [DATA_W-1:0] r_re_q [c_depth];
  logic [DATA_W-1:0] r_im_q [c_depth];
  logic [DATA_W-1:0] r_wr_q [c_depth];
  logic [DATA_W-1:0] r_wi_q [c_depth];
  logic [IDX_W-1:0]  r_idx_q [c_depth];
  logic              r_last_q [c_depth];

  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err;

  logic              w_push;
  logic              w_pop;
  logic              w_at_end;
  logic [IDX_W-1:0]  w_idx_next;
  logic [DATA_W-1:0] w_tw_r;
  logic [DATA_W-1:0] w_tw_i;

  assign in_ready   = (r_count < 2'(c_depth));
  assign out_valid  = (r_count != 2'd0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_at_end   = (r_idx == c_last_idx);
  // An early in_last resyncs the counter to the start of the next frame.
  assign w_idx_next = (w_at_end || in_last) ? '0 : r_idx + 1'b1;
  assign w_tw_r     = w64r[r_idx];
  assign w_tw_i     = w64i[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_re_q[i]   <= '0;
        r_im_q[i]   <= '0;
        r_wr_q[i]   <= '0;
        r_wi_q[i]   <= '0;
        r_idx_q[i]  <= '0;
        r_last_q[i] <= 1'b0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_re_q[r_wptr]   <= in_re;
        r_im_q[r_wptr]   <= in_im;
        r_wr_q[r_wptr]   <= w_tw_r;
        r_wi_q[r_wptr]   <= w_tw_i;
        r_idx_q[r_wptr]  <= r_idx;
        r_last_q[r_wptr] <= w_at_end;
        r_wptr           <= ~r_wptr;
        r_idx            <= w_idx_next;
        if (in_last != w_at_end) begin
          r_err <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_re    = r_re_q[r_rptr];
  assign out_im    = r_im_q[r_rptr];
  assign out_wr    = r_wr_q[r_rptr];
  assign out_wi    = r_wi_q[r_rptr];
  assign out_idx   = r_idx_q[r_rptr];
  assign out_last  = r_last_q[r_rptr];
  assign frame_err = r_err;

`ifdef TWIDDLE_TRIVIAL_EN
  localparam logic [DATA_W-1:0] c_one = DATA_W'(32'h3f80_0000);

  logic r_triv_q [c_depth];
  logic w_triv;

  // Flag travels with the entry so later table changes cannot affect it.
  assign w_triv = (w_tw_r == c_one) && (w_tw_i == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_triv_q[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_triv_q[r_wptr] <= w_triv;
    end
  end

  assign out_trivial = r_triv_q[r_rptr];
`else
  assign out_trivial = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft64_twiddle_sequencer.sv
`default_nettype none
// Directed bench for fft64_twiddle_sequencer with a queue scoreboard sampled on negedge.
module tb_fft64_twiddle_sequencer;

  logic              clk;
  logic              rst;
  logic [63:0][31:0] tw_r;
  logic [63:0][31:0] tw_i;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_re;
  logic [31:0]       in_im;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_re;
  logic [31:0]       out_im;
  logic [31:0]       out_wr;
  logic [31:0]       out_wi;
  logic [5:0]        out_idx;
  logic              out_last;
  logic              out_trivial;
  logic              frame_err;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [31:0] wr;
    logic [31:0] wi;
    logic [5:0]  idx;
    logic        last;
    logic        triv;
  } ent_t;

  ent_t     sb[$];
  ent_t     h;
  ent_t     e;
  logic [5:0] m_idx;
  logic     m_err;
  logic     rnd;
  int       n_vec;
  int       n_miss;

  fft64_twiddle_sequencer #(
    .DATA_W   (32),
    .FRAME_LEN(64),
    .IDX_W    (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w64r       (tw_r),
    .w64i       (tw_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_wr     (out_wr),
    .out_wi     (out_wi),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_trivial(out_trivial),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trivial (1+0j) at 0..16, 32, 48; two real table values at 17 and 40.
  task automatic build_table();
    for (int k = 0; k < 64; k++) begin
      if (k <= 16 || k == 32 || k == 48) begin
        tw_r[k] = 32'h3f80_0000;
        tw_i[k] = 32'h0000_0000;
      end else begin
        tw_r[k] = 32'h3e00_0000 | 32'(k);
        tw_i[k] = 32'hbe00_0000 | (32'(k) << 8);
      end
    end
    tw_r[17] = 32'h3f7e_c46d;
    tw_i[17] = 32'hbdc8_bd36;
    tw_r[40] = 32'h248d_3132;
    tw_i[40] = 32'hbf80_0000;
  endtask

  task automatic push_one(input logic [31:0] re, input logic [31:0] im, input logic last);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    n        = 0;
    do begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) check_eq("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: compare head against model, then apply this edge's pop and push.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_idx = '0;
        m_err = 1'b0;
      end else begin
        check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        check_eq("frame_err", 64'(frame_err), 64'(m_err));
        if (sb.size() != 0 && out_valid) begin
          h = sb[0];
          check_eq("out_re", 64'(out_re), 64'(h.re));
          check_eq("out_im", 64'(out_im), 64'(h.im));
          check_eq("out_wr", 64'(out_wr), 64'(h.wr));
          check_eq("out_wi", 64'(out_wi), 64'(h.wi));
          check_eq("out_idx", 64'(out_idx), 64'(h.idx));
          check_eq("out_last", 64'(out_last), 64'(h.last));
          check_eq("out_trivial", 64'(out_trivial), 64'(h.triv));
          if (h.idx == 6'd17) check_eq("wr17", 64'(out_wr), 64'h3f7e_c46d);
          if (h.idx == 6'd17) check_eq("wi17", 64'(out_wi), 64'hbdc8_bd36);
          if (h.idx == 6'd40) check_eq("wr40", 64'(out_wr), 64'h248d_3132);
          if (h.idx == 6'd40) check_eq("wi40", 64'(out_wi), 64'hbf80_0000);
          if (out_ready) void'(sb.pop_front());
        end
        if (in_valid && in_ready) begin
          e.re   = in_re;
          e.im   = in_im;
          e.wr   = tw_r[m_idx];
          e.wi   = tw_i[m_idx];
          e.idx  = m_idx;
          e.last = (m_idx == 6'd63);
`ifdef TWIDDLE_TRIVIAL_EN
          e.triv = (tw_r[m_idx] == 32'h3f80_0000) && (tw_i[m_idx] == 32'h0);
`else
          e.triv = 1'b0;
`endif
          sb.push_back(e);
          if (in_last != (m_idx == 6'd63)) m_err = 1'b1;
          m_idx = (m_idx == 6'd63 || in_last) ? 6'd0 : m_idx + 6'd1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    m_idx     = '0;
    m_err     = 1'b0;
    rnd       = 1'b0;
    build_table();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_err", 64'(frame_err), 64'd0);
    check_eq("rst_re", 64'(out_re), 64'd0);
    check_eq("rst_wr", 64'(out_wr), 64'd0);
    check_eq("rst_idx", 64'(out_idx), 64'd0);
    check_eq("rst_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_rdy", 64'(in_ready), 64'd1);

    // One full frame back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) push_one(32'h4000_0000 + 32'(i), 32'h0, i == 63);
    drain();
    check_eq("frame1_err", 64'(frame_err), 64'd0);

    // Backpressure: two accepts fill the FIFO, third held.
    out_ready = 1'b0;
    push_one(32'hA000_0000, 32'hB000_0000, 1'b0);
    push_one(32'hA000_0001, 32'hB000_0001, 1'b0);
    check_eq("full_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_re    = 32'hA000_0002;
    in_im    = 32'hB000_0002;
    tick();
    tick();
    check_eq("hold_rdy", 64'(in_ready), 64'd0);
    check_eq("hold_idx", 64'(out_idx), 64'd0);
    tw_r[0] = 32'hDEAD_BEEF;
    tw_i[1] = 32'h1234_5678;
    out_ready = 1'b1;
    push_one(32'hA000_0002, 32'hB000_0002, 1'b0);
    drain();
    build_table();

    // Reset with two entries buffered mid-frame.
    out_ready = 1'b0;
    push_one(32'hC000_0000, 32'hC100_0000, 1'b0);
    push_one(32'hC000_0001, 32'hC100_0001, 1'b0);
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Two frames with random downstream stalls.
    rnd = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) push_one($urandom, $urandom, i == 63);
    end
    rnd = 1'b0;
    drain();
    check_eq("frame2_err", 64'(frame_err), 64'd0);

    // Early in_last at sample 10.
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) push_one(32'(i), ~32'(i), i == 10);
    push_one(32'h0000_0077, 32'h0000_0088, 1'b0);
    drain();
    check_eq("err_set", 64'(frame_err), 64'd1);
    repeat (5) tick();
    check_eq("err_sticky", 64'(frame_err), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("err_clear", 64'(frame_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft64_twiddle_sequencer.md
Name: fft64_twiddle_sequencer

Overview:
Consumer of the 64-entry radix-4 twiddle table (w64r/w64i, IEEE-754 single precision) in the 64-point FFT datapath. It accepts a stream of complex samples, counts position within each 64-sample frame, and pairs each sample with twiddle[index]. The pair goes through a 2-entry buffered valid/ready interface to the downstream complex multiplier. It also checks frame alignment.

Parameters:
DATA_W, 32, width of each real/imag component (IEEE single).
FRAME_LEN, 64, samples per frame; index counter wraps at FRAME_LEN-1.
IDX_W, 6, index counter width = log2(FRAME_LEN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
w64r  in  DATA_W x FRAME_LEN  twiddle real table, from the twiddle ROM.
w64i  in  DATA_W x FRAME_LEN  twiddle imag table, from the twiddle ROM.
in_valid  in  1  upstream sample valid.
in_ready  out  1  block can accept a sample.
in_re  in  DATA_W  sample real.
in_im  in  DATA_W  sample imag.
in_last  in  1  upstream marks final sample of frame.
out_valid  out  1  output pair valid.
out_ready  in  1  downstream accepts.
out_re, out_im  out  DATA_W  sample passthrough.
out_wr, out_wi  out  DATA_W  twiddle for this sample.
out_idx  out  IDX_W  frame position of this sample.
out_last  out  1  high when out_idx == FRAME_LEN-1.
out_trivial  out  1  twiddle is exactly 1+0j (see Optional Feature).
frame_err  out  1  sticky alignment error flag.

Behaviour:
- Reset (async, rst=1): idx=0, buffer empty, out_valid=0, in_ready=1 once rst drops, frame_err=0, all data outputs 0.
- Accept: in_valid && in_ready. The block pushes {in_re, in_im, w64r[idx], w64i[idx], idx, idx==FRAME_LEN-1} into a 2-entry FIFO.
- idx advances by 1 on every accept and wraps from FRAME_LEN-1 to 0.
- Pop: out_valid && out_ready. Outputs always show the FIFO head. Data is stable while out_valid=1 and out_ready=0.
- Latency: sample accepted in cycle N appears on outputs in cycle N+1 if the FIFO was empty.
- in_ready is a register function: in_ready = (occupancy < 2). It does not depend combinationally on out_ready.
- Throughput: one sample per cycle when out_ready is held high.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and the head is replaced by the new entry.
- Full (occupancy 2) with a pop: in_ready goes high the following cycle.
- Empty: out_valid=0 and no pop occurs.
- Frame check, on accept:
  - in_last=1 with idx != FRAME_LEN-1: frame_err sets, idx resyncs to 0, and the entry is emitted with out_last=0.
  - in_last=0 with idx == FRAME_LEN-1: frame_err sets, idx still wraps to 0.
  - frame_err clears only on rst.
- Twiddle table inputs are sampled at the push cycle. Table changes never alter entries already in the FIFO.
- rst mid-frame: FIFO is flushed, idx returns to 0, and partial frame data is discarded with no output.
- No arithmetic is performed on sample data; it is a bit-exact passthrough.

Optional Feature:
Macro TWIDDLE_TRIVIAL_EN.
- Defined: out_trivial=1 when the stored twiddle equals 32'h3f800000 / 32'h00000000, i.e. indices 0-16, 32 and 48 of the standard table. The flag is computed at push time and stored in the FIFO with the entry. The downstream multiplier uses it to bypass its multiply.
- Not defined: out_trivial is tied to 0 and no comparators are built.

Test Plan:
- Reset, then 64 back-to-back samples (re=idx as float bits, im=0), out_ready=1, in_last on sample 63 -> outputs cycles 1..64; out_idx 0..63; idx 17 yields wr=3f7ec46d, wi=bdc8bd36; idx 40 yields wr=248d3132, wi=bf800000; out_last only at idx 63; frame_err=0.
- out_ready=0 while pushing 3 samples -> in_ready falls after 2 accepts; third sample held. Raise out_ready -> outputs in order idx 0,1,2 with no loss or duplication.
- Random out_ready (50%) across 2 frames -> in-order, bit-exact passthrough; idx wraps 63->0 between frames.
- in_last asserted on sample 10 -> frame_err=1; next accepted sample gets out_idx=0; frame_err stays 1 until rst.
- rst asserted with 2 entries buffered mid-frame -> out_valid=0 immediately (async); after release, first sample gets out_idx=0.
- TWIDDLE_TRIVIAL_EN defined -> out_trivial=1 at idx 0,5,16,32,48 and 0 at idx 17,33,63. Macro undefined -> always 0.
